awg_ctrl: RTL
=============

// Module: awg_ctrl
// PURPOSE
//  Host-side controller for the waveform generator. Decodes a byte-stream command protocol (valid/ready).
//  Drives the generator's load strobe, table address, sample data, prescaler and mode select.
//  Sits between the host byte interface (UART/SPI deserialiser) and the generator's ld/addr/in/pre/sel ports.
// PARAMETERS
//  NBITS    12      sample width; must be 9..16 (sample = 2 bytes, MSB first)
//  PTBITS   10      table address width; must be <=16
//  TMO_CYC  100000  max ck cycles between bytes inside a command before abort; >=2
// PORTS
//  ck        in   1       clock, all logic on rising edge
//  rst_n     in   1       asynchronous active-low reset
//  rx_data   in   8       command/data byte from host
//  rx_valid  in   1       rx_data valid
//  rx_ready  out  1       byte accepted when rx_valid & rx_ready on a ck edge
//  awg_ld    out  1       table write strobe to generator
//  awg_addr  out  PTBITS  table write address
//  awg_in    out  NBITS   sample data (load) or direct output value (direct mode)
//  awg_pre   out  4       playback prescaler
//  awg_sel   out  1       0 = direct value, 1 = table playback
//  busy      out  1       high while any command is in progress (state != IDLE)
//  err       out  1       sticky error; cleared when the next command byte is accepted in IDLE
// BEHAVIOUR
//  Reset: rx_ready=0, awg_ld=0, awg_addr=0, awg_in=0, awg_pre=0, awg_sel=0, busy=0, err=0, FSM=IDLE.
//  Reset is honoured mid-command: partial load abandoned, no further writes; table contents are untouched.
//  rx_ready=1 in every byte-collecting state, 0 in WR1/WR2 and for the first cycle after reset release.
//  Commands (first byte, accepted in IDLE):
//   0x01 SET_PRE  +1 byte: awg_pre <= byte[3:0] on accept of the arg byte.
//   0x02 SET_MODE +1 byte: awg_sel <= byte[0].
//   0x03 SET_DIR  +2 bytes (MSB first): direct register <= {hi,lo}[NBITS-1:0].
//     awg_in shows the direct register whenever not in WR1/WR2.
//   0x04 LOAD     +2 addr bytes, +2 count bytes N, then N samples x 2 bytes.
//   Any other opcode: err<=1, stay IDLE, byte consumed.
//  FSM: IDLE -> ARG1 -> ARG2 (SET_*); LOAD: IDLE->A_HI->A_LO->N_HI->N_LO->D_HI->D_LO->WR1->WR2->D_HI|DONE.
//  Write sequence per sample: on D_LO accept, latch sample and address.
//   WR1: awg_ld=1, awg_addr/awg_in stable.
//   WR2: awg_ld=1, same addr/data.
//   The generator registers the address one cycle before the data write, so the two-cycle strobe is mandatory.
//   Addr/data hold through WR2; awg_ld=0 afterwards.
//  Address = start[PTBITS-1:0]; +1 per sample, wraps modulo 2^PTBITS; upper address-byte bits ignored.
//  N=0: LOAD completes right after N_LO, no writes. N>2^PTBITS: later samples overwrite (wrap).
//  Sample bits above NBITS-1 ignored. Sample counter is 16 bits; done when remaining==0 after WR2.
//  awg_sel/awg_pre unchanged by LOAD; playback continues during load (host may SET_MODE 0 first).
//  Timeout: in any non-IDLE byte-collecting state, a counter restarts on each accepted byte.
//   Reaching TMO_CYC -> err<=1, FSM->IDLE. Samples already written remain.
//  DONE is a single-cycle state; busy drops the cycle after it. Back-to-back commands need no gap.
// CONFIGURATION
//  AWG_CTRL_CHKSUM_EN defined:
//   LOAD takes one extra byte after the last sample: XOR of all sample bytes (addr/count excluded).
//   Mismatch -> err<=1 (writes already done are kept). Timeout also applies to that byte.
//  Not defined: no checksum byte; LOAD ends after the last WR2.
// TESTING
//  1 Reset mid-LOAD (after 3 samples) -> all outputs reset values, awg_ld=0, next cmd 0x01 0x05 -> awg_pre=5.
//  2 LOAD 0x04 00 10 00 02 0A BC 03 21 -> writes 0xABC@0x010, 0x321@0x011.
//    Each write: awg_ld high exactly 2 cycles, addr/data stable; busy low after DONE.
//  3 LOAD addr 0x3FF, N=2 -> writes at 0x3FF then 0x000 (wrap); LOAD with N=0 -> no awg_ld pulse, busy<=~8 cycles.
//  4 Opcode 0x7F -> err=1, rx_ready stays 1.
//    0x03 0x08 0x00 -> err clears on the 0x03 accept, awg_in=0x800 with awg_sel=0.
//  5 LOAD stalls after A_LO for TMO_CYC cycles -> err=1, busy=0; no awg_ld; next valid cmd accepted.
//  6 (CHKSUM_EN) Sample bytes 0A BC, checksum 0xB6 -> err=0; checksum 0x00 -> err=1, sample still written.

Source files
------------

// File: rtl/awg_ctrl.sv
// awg_ctrl: decodes the host byte-stream command protocol into generator load/config outputs.
// Build option AWG_CTRL_CHKSUM_EN: LOAD ends with one XOR checksum byte over all sample bytes.
module awg_ctrl #(
    parameter int NBITS   = 12,
    parameter int PTBITS  = 10,
    parameter int TMO_CYC = 100000
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              awg_ld,
    output logic [PTBITS-1:0] awg_addr,
    output logic [NBITS-1:0]  awg_in,
    output logic [3:0]        awg_pre,
    output logic              awg_sel,
    output logic              busy,
    output logic              err
);
    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, ARG1, ARG2, A_HI, A_LO, N_HI, N_LO, D_HI, D_LO, WR1, WR2, CHK, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [7:0]        hi_q, hi_d;
    logic [PTBITS-1:0] nxt_addr_q, nxt_addr_d, wr_addr_q, wr_addr_d;
    logic [NBITS-1:0]  smp_q, smp_d, dir_q, dir_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [3:0]        pre_q, pre_d;
    logic              sel_q, sel_d, err_q, err_d, rdy_en_q, rdy_en_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              coll, acc, tmo_run;
    logic [15:0]       pair;

    // Every state except the write strobe and DONE is waiting for a byte.
    always_comb begin
        case (state_q)
            WR1, WR2, DONE: coll = 1'b0;
            default:        coll = 1'b1;
        endcase
    end

    assign rx_ready = rdy_en_q & coll;
    assign acc      = rx_valid & rx_ready;
    assign pair     = {hi_q, rx_data};
    assign tmo_run  = coll && (state_q != IDLE) && !acc;
    assign rdy_en_d = 1'b1;

`ifdef AWG_CTRL_CHKSUM_EN
    logic [7:0] xor_q, xor_d;

    always_comb begin
        xor_d = xor_q;
        if (state_q == N_LO)
            xor_d = '0;
        else if (acc && (state_q == D_HI || state_q == D_LO))
            xor_d = xor_q ^ rx_data;
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) xor_q <= '0;
        else        xor_q <= xor_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hi_d       = hi_q;
        nxt_addr_d = nxt_addr_q;
        wr_addr_d  = wr_addr_q;
        smp_d      = smp_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        sel_d      = sel_q;
        err_d      = err_q;
        tmo_d      = tmo_run ? tmo_q + 1'b1 : '0;
        case (state_q)
            IDLE: if (acc) begin
                err_d = 1'b0;
                op_d  = rx_data[1:0];
                case (rx_data)
                    8'h01, 8'h02, 8'h03: state_d = ARG1;
                    8'h04:               state_d = A_HI;
                    default:             err_d   = 1'b1;
                endcase
            end
            ARG1: if (acc) begin
                hi_d = rx_data;
                if (op_q == 2'd1) begin
                    pre_d   = rx_data[3:0];
                    state_d = IDLE;
                end else if (op_q == 2'd2) begin
                    sel_d   = rx_data[0];
                    state_d = IDLE;
                end else begin
                    state_d = ARG2;
                end
            end
            ARG2: if (acc) begin
                dir_d   = pair[NBITS-1:0];
                state_d = IDLE;
            end
            A_HI: if (acc) begin
                hi_d    = rx_data;
                state_d = A_LO;
            end
            A_LO: if (acc) begin
                nxt_addr_d = pair[PTBITS-1:0];
                state_d    = N_HI;
            end
            N_HI: if (acc) begin
                hi_d    = rx_data;
                state_d = N_LO;
            end
            N_LO: if (acc) begin
                cnt_d   = pair;
                state_d = (pair == 16'd0) ? DONE : D_HI;
            end
            D_HI: if (acc) begin
                hi_d    = rx_data;
                state_d = D_LO;
            end
            // Address and data are captured together so both stay frozen across WR1/WR2.
            D_LO: if (acc) begin
                smp_d      = pair[NBITS-1:0];
                wr_addr_d  = nxt_addr_q;
                nxt_addr_d = nxt_addr_q + 1'b1;
                cnt_d      = cnt_q - 16'd1;
                state_d    = WR1;
            end
            WR1: state_d = WR2;
            WR2: begin
                if (cnt_q != 16'd0)
                    state_d = D_HI;
                else
`ifdef AWG_CTRL_CHKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
            end
`ifdef AWG_CTRL_CHKSUM_EN
            CHK: if (acc) begin
                if (rx_data != xor_q) err_d = 1'b1;
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (tmo_run && tmo_q == TW'(TMO_CYC - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            hi_q       <= '0;
            nxt_addr_q <= '0;
            wr_addr_q  <= '0;
            smp_q      <= '0;
            dir_q      <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            sel_q      <= 1'b0;
            err_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            nxt_addr_q <= nxt_addr_d;
            wr_addr_q  <= wr_addr_d;
            smp_q      <= smp_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            rdy_en_q   <= rdy_en_d;
            tmo_q      <= tmo_d;
        end
    end

    assign awg_ld   = (state_q == WR1) || (state_q == WR2);
    assign awg_addr = wr_addr_q;
    assign awg_in   = awg_ld ? smp_q : dir_q;
    assign awg_pre  = pre_q;
    assign awg_sel  = sel_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
endmodule
